// File: rtl/fpu_scoreboard_pkg.sv
// Shared core definitions for the FPU issue scoreboard: default latency sizing
// and the 6-bit {file, number} register identifier.
package fpu_scoreboard_pkg;

  localparam int SB_MAX_LAT = 15;
  localparam int SB_LAT_W   = 4;
  localparam int NUM_REGS   = 64;

  typedef struct packed {
    logic       fpu;
    logic [4:0] num;
  } reg_id_t;

  // Integer x0 is hardwired to zero and can never be pending.
  function automatic logic is_int_x0(input reg_id_t id);
    return (id.fpu == 1'b0) && (id.num == 5'd0);
  endfunction

endpackage

// File: rtl/sb_wb_slots.sv
// Writeback-slot tracker: bit k of the slot vector means a result lands k cycles from now.
// Implemented only when SB_WB_ARBITER_EN is defined; otherwise it reports no conflict and never busy.
module sb_wb_slots
  import fpu_scoreboard_pkg::*;
#(
  parameter int MAX_LAT = SB_MAX_LAT,
  parameter int LAT_W   = SB_LAT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             accept,
  input  logic [LAT_W-1:0] lat,
  output logic             conflict,
  output logic             busy
);

`ifdef SB_WB_ARBITER_EN
  logic [MAX_LAT:1] wb_r;
  logic [MAX_LAT:1] wb_nxt_s;
  logic             conflict_s;

  // Slot lookup for the offered latency and the shifted/loaded next slot vector.
  always_comb begin
    wb_nxt_s   = '0;
    conflict_s = 1'b0;
    for (int k = 1; k <= MAX_LAT; k++) begin
      conflict_s = conflict_s | (wb_r[k] & (lat == LAT_W'(k)));
    end
    // A latency-1 result lands next cycle, so it never occupies a future slot.
    for (int k = 1; k < MAX_LAT; k++) begin
      wb_nxt_s[k] = wb_r[k+1] | (accept & (lat == LAT_W'(k + 1)));
    end
  end

  // Slot vector register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_r <= '0;
    end else begin
      wb_r <= wb_nxt_s;
    end
  end

  assign conflict = conflict_s;
  assign busy     = |wb_r;
`else
  logic unused_s;
  assign unused_s = ^{clk, rst, accept, lat};
  assign conflict = 1'b0;
  assign busy     = 1'b0;
`endif

endmodule

// File: rtl/fpu_scoreboard.sv
// Issue scoreboard for the int/FPU register files: per-register pending latency
// counters gate RAW/WAW hazards; the writeback-slot check is built with SB_WB_ARBITER_EN.
module fpu_scoreboard
  import fpu_scoreboard_pkg::*;
#(
  parameter int MAX_LAT = SB_MAX_LAT,
  parameter int LAT_W   = SB_LAT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_dp,
  input  logic [4:0]       rs2_dp,
  input  logic [4:0]       rs3_dp,
  input  logic [2:0]       rs_fpu_dp,
  input  logic             rs3_used_dp,
  input  logic             issue_valid,
  input  logic [4:0]       issue_rd,
  input  logic             issue_rd_fpu,
  input  logic             issue_wr,
  input  logic [LAT_W-1:0] issue_lat,
  input  logic             flush,
  output logic             stall_dp,
  output logic             idle
);

  reg_id_t          src1_s, src2_s, src3_s, dst_s;
  logic [LAT_W-1:0] pend_r [NUM_REGS];
  logic [LAT_W-1:0] lat_s;
  logic             raw_s, waw_s, conflict_s, busy_s;
  logic             accept_s, load_s, any_pend_s;

  // Out-of-range latencies behave as single-cycle operations.
  function automatic logic [LAT_W-1:0] eff_lat(input logic [LAT_W-1:0] lat);
    if ((lat == {LAT_W{1'b0}}) || (lat > LAT_W'(MAX_LAT))) begin
      return LAT_W'(1);
    end else begin
      return lat;
    end
  endfunction

  assign src1_s = {rs_fpu_dp[2], rs1_dp};
  assign src2_s = {rs_fpu_dp[1], rs2_dp};
  assign src3_s = {rs_fpu_dp[0], rs3_dp};
  assign dst_s  = {issue_rd_fpu, issue_rd};
  assign lat_s  = eff_lat(issue_lat);

  // A counter of 1 means the value is forwarded this cycle, so only >= 2 blocks a reader.
  assign raw_s = (pend_r[src1_s] > LAT_W'(1)) |
                 (pend_r[src2_s] > LAT_W'(1)) |
                 (rs3_used_dp & (pend_r[src3_s] > LAT_W'(1)));
  assign waw_s = issue_wr & (pend_r[dst_s] > lat_s);

  assign stall_dp = ~rst & issue_valid & (raw_s | waw_s | (issue_wr & conflict_s));
  assign accept_s = issue_valid & ~stall_dp & ~flush;
  assign load_s   = accept_s & issue_wr & ~is_int_x0(dst_s);

  sb_wb_slots #(
    .MAX_LAT (MAX_LAT),
    .LAT_W   (LAT_W)
  ) u_wb_slots (
    .clk      (clk),
    .rst      (rst),
    .accept   (accept_s & issue_wr),
    .lat      (lat_s),
    .conflict (conflict_s),
    .busy     (busy_s)
  );

  // Pending counters: load on an accepted write, otherwise count down to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        pend_r[i] <= {LAT_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (load_s && (dst_s == 6'(i))) begin
          pend_r[i] <= lat_s;
        end else if (pend_r[i] != {LAT_W{1'b0}}) begin
          pend_r[i] <= pend_r[i] - LAT_W'(1);
        end else begin
          pend_r[i] <= pend_r[i];
        end
      end
    end
  end

  // Any register still waiting for its writeback.
  always_comb begin
    any_pend_s = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      any_pend_s = any_pend_s | (pend_r[i] != {LAT_W{1'b0}});
    end
  end

  assign idle = rst | (~any_pend_s & ~busy_s);

endmodule

// File: tb/tb_fpu_scoreboard.sv
// Self-checking bench for fpu_scoreboard: directed hazard scenarios plus random traffic
// compared every cycle against a model that tracks absolute writeback times.
module tb_fpu_scoreboard;

  localparam int MAX_LAT = 15;
  localparam int LAT_W   = 4;
`ifdef SB_WB_ARBITER_EN
  localparam int EXP_STRUCT = 1;
`else
  localparam int EXP_STRUCT = 0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       rs1_dp, rs2_dp, rs3_dp;
  logic [2:0]       rs_fpu_dp;
  logic             rs3_used_dp, issue_valid, issue_rd_fpu, issue_wr, flush;
  logic [4:0]       issue_rd;
  logic [LAT_W-1:0] issue_lat;
  logic             stall_dp, idle;

  int n_checks = 0;
  int n_fail   = 0;
  bit last_stall;

  // Model: absolute cycle at which each register's counter reaches zero, and
  // the set of absolute cycles that already own a writeback slot.
  int now_c = 0;
  int wb_time [64];
  bit occ [int];

  always #5 clk = ~clk;

  fpu_scoreboard #(.MAX_LAT(MAX_LAT), .LAT_W(LAT_W)) dut (
    .clk(clk), .rst(rst), .rs1_dp(rs1_dp), .rs2_dp(rs2_dp), .rs3_dp(rs3_dp),
    .rs_fpu_dp(rs_fpu_dp), .rs3_used_dp(rs3_used_dp), .issue_valid(issue_valid),
    .issue_rd(issue_rd), .issue_rd_fpu(issue_rd_fpu), .issue_wr(issue_wr),
    .issue_lat(issue_lat), .flush(flush), .stall_dp(stall_dp), .idle(idle)
  );

  function automatic int eff(int l);
    return ((l == 0) || (l > MAX_LAT)) ? 1 : l;
  endfunction

  function automatic int cnt(int idx);
    return (wb_time[idx] > now_c) ? (wb_time[idx] - now_c) : 0;
  endfunction

  function automatic bit m_stall();
    bit raw, waw, st;
    if (rst || !issue_valid) return 1'b0;
    raw = (cnt(int'({rs_fpu_dp[2], rs1_dp})) >= 2) || (cnt(int'({rs_fpu_dp[1], rs2_dp})) >= 2) ||
          (rs3_used_dp && (cnt(int'({rs_fpu_dp[0], rs3_dp})) >= 2));
    waw = issue_wr && (cnt(int'({issue_rd_fpu, issue_rd})) > eff(int'(issue_lat)));
    st  = (EXP_STRUCT != 0) && issue_wr && occ.exists(now_c + eff(int'(issue_lat)));
    return raw || waw || st;
  endfunction

  function automatic bit m_idle();
    if (rst) return 1'b1;
    for (int i = 0; i < 64; i++) if (cnt(i) != 0) return 1'b0;
    if (EXP_STRUCT != 0) foreach (occ[t]) if (t > now_c) return 1'b0;
    return 1'b1;
  endfunction

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, now_c);
    end
  endtask

  // One clock: compare at mid-cycle, then advance the model on the edge.
  task automatic tick();
    bit acc;
    int l;
    #4;
    check("stall_dp", int'(stall_dp), int'(m_stall()));
    check("idle", int'(idle), int'(m_idle()));
    last_stall = stall_dp;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 64; i++) wb_time[i] = 0;
      occ.delete();
    end else begin
      acc = issue_valid && !m_stall() && !flush;
      l   = eff(int'(issue_lat));
      if (acc && issue_wr && ({issue_rd_fpu, issue_rd} != 6'd0)) wb_time[{issue_rd_fpu, issue_rd}] = now_c + 1 + l;
      if (acc && issue_wr && (l >= 2)) occ[now_c + l] = 1'b1;
    end
    now_c++;
    #1;
  endtask

  task automatic offer(input bit v, input bit w, input bit [5:0] dst, input int lat, input bit [5:0] s1);
    issue_valid = v;
    issue_wr    = w;
    {issue_rd_fpu, issue_rd} = dst;
    issue_lat   = LAT_W'(lat);
    {rs_fpu_dp[2], rs1_dp} = s1;
    rs_fpu_dp[1:0] = 2'b00;
    rs2_dp = 5'd0;
    rs3_dp = 5'd0;
    rs3_used_dp = 1'b0;
    flush = 1'b0;
  endtask

  // Hold the current offer until accepted (bounded) and return the stall count.
  task automatic count_stalls(output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!last_stall) break;
      n++;
    end
    offer(1'b0, 1'b0, 6'd0, 1, 6'd0);
  endtask

  task automatic drain();
    offer(1'b0, 1'b0, 6'd0, 1, 6'd0);
    repeat (17) tick();
  endtask

  initial begin
    int n;
    for (int i = 0; i < 64; i++) wb_time[i] = 0;
    rst = 1'b1;
    offer(1'b1, 1'b1, 6'h23, 4, 6'h23);
    tick();
    tick();
    check("rst_stall_low", int'(last_stall), 0);
    check("rst_idle_high", int'(idle), 1);

    rst = 1'b0;
    offer(1'b1, 1'b0, 6'd0, 1, 6'h23);
    tick();
    check("post_rst_ready", int'(last_stall), 0);

    // RAW on f3 with latency 4
    offer(1'b1, 1'b1, 6'h23, 4, 6'h00);
    tick();
    offer(1'b1, 1'b0, 6'd0, 1, 6'h23);
    count_stalls(n);
    check("raw_stalls", n, 3);
    drain();

    // File separation and x0
    offer(1'b1, 1'b1, 6'h23, 4, 6'h00);
    tick();
    offer(1'b1, 1'b0, 6'd0, 1, 6'h03);
    tick();
    check("int_x3_no_stall", int'(last_stall), 0);
    offer(1'b1, 1'b1, 6'h00, 5, 6'h00);
    tick();
    offer(1'b1, 1'b0, 6'd0, 1, 6'h00);
    tick();
    check("x0_no_stall", int'(last_stall), 0);
    drain();
    check("drained_idle", int'(idle), 1);

    // WAW on f5
    offer(1'b1, 1'b1, 6'h25, 6, 6'h00);
    tick();
    offer(1'b1, 1'b1, 6'h25, 2, 6'h00);
    count_stalls(n);
    check("waw_stalls", n, 4);
    drain();

    // Writeback slot collision
    offer(1'b1, 1'b1, 6'h21, 3, 6'h00);
    tick();
    offer(1'b1, 1'b1, 6'h22, 2, 6'h00);
    count_stalls(n);
    check("struct_stalls", n, EXP_STRUCT);
    drain();

    // Flush: stall still reflects RAW, and a flushed write loads nothing
    offer(1'b1, 1'b1, 6'h23, 4, 6'h00);
    tick();
    offer(1'b1, 1'b0, 6'd0, 1, 6'h23);
    flush = 1'b1;
    tick();
    check("flush_raw_stall", int'(last_stall), 1);
    offer(1'b1, 1'b1, 6'h27, 9, 6'h00);
    flush = 1'b1;
    tick();
    check("flush_write_no_stall", int'(last_stall), 0);
    offer(1'b1, 1'b0, 6'd0, 1, 6'h27);
    tick();
    check("flushed_no_load", int'(last_stall), 0);

    // Reset mid-flight
    offer(1'b1, 1'b1, 6'h29, 10, 6'h00);
    tick();
    offer(1'b0, 1'b0, 6'd0, 1, 6'h00);
    tick();
    check("busy_before_rst", int'(idle), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("idle_after_rst", int'(idle), 1);
    offer(1'b1, 1'b0, 6'd0, 1, 6'h29);
    tick();
    check("ready_after_rst", int'(last_stall), 0);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rst          = ($urandom_range(0, 299) == 0);
      issue_valid  = ($urandom_range(0, 9) < 7);
      issue_wr     = ($urandom_range(0, 9) < 7);
      issue_rd_fpu = 1'($urandom_range(0, 1));
      issue_rd     = 5'($urandom_range(0, 3));
      issue_lat    = LAT_W'($urandom_range(0, 15));
      rs1_dp       = 5'($urandom_range(0, 3));
      rs2_dp       = 5'($urandom_range(0, 3));
      rs3_dp       = 5'($urandom_range(0, 3));
      rs_fpu_dp    = 3'($urandom_range(0, 7));
      rs3_used_dp  = 1'($urandom_range(0, 1));
      flush        = ($urandom_range(0, 7) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fpu_scoreboard.md
FPU_SCOREBOARD -- requirements
Module: fpu_scoreboard

Interface
REQ-001 SHALL have parameter MAX_LAT, default 15, meaning the largest issue latency in cycles (1..15).
REQ-002 SHALL have parameter LAT_W, default 4, meaning the latency/counter width (LAT_W >= clog2(MAX_LAT+1)).
REQ-003 SHALL have port clk, input, 1, meaning the sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, meaning synchronous active-high reset.
REQ-005 SHALL have port rs1_dp / rs2_dp / rs3_dp, input, 5 each, meaning the DP-stage source register numbers.
REQ-006 SHALL have port rs_fpu_dp, input, 3, meaning source-in-FPU-file flags; bit2=rs1, bit1=rs2, bit0=rs3.
REQ-007 SHALL have port rs3_used_dp, input, 1, meaning rs3 is a live operand.
REQ-008 SHALL have port issue_valid, input, 1, meaning the DP stage offers an instruction this cycle.
REQ-009 SHALL have port issue_rd, input, 5, meaning the destination register number.
REQ-010 SHALL have port issue_rd_fpu, input, 1, meaning the destination is in the FPU file.
REQ-011 SHALL have port issue_wr, input, 1, meaning the instruction writes a register.
REQ-012 SHALL have port issue_lat, input, LAT_W, meaning cycles from issue to writeback.
REQ-013 SHALL have port flush, input, 1, meaning kill the instruction currently offered.
REQ-014 SHALL have port stall_dp, output, 1, meaning hold DP; the offered instruction is not accepted.
REQ-015 SHALL have port idle, output, 1, meaning no register write is pending.

Function
REQ-016 SHALL keep 64 pending counters pend[f][r] (f = file, r = register), each LAT_W bits wide; 0 means not pending.
REQ-017 SHALL assert accept = issue_valid & ~stall_dp & ~flush.
REQ-018 SHALL decrement every nonzero counter by 1 each cycle.
REQ-019 SHALL load pend[issue_rd_fpu][issue_rd] with issue_lat on accept & issue_wr; the load overrides the decrement.
REQ-020 SHALL never mark integer x0 pending: an accepted write to int x0 is ignored.
REQ-021 SHALL treat a source as ready when its counter <= 1, because a value in the final cycle is covered by forwarding.
REQ-022 SHALL raise a RAW hazard when issue_valid and any live source counter >= 2; rs3 is live only when rs3_used_dp.
REQ-023 SHALL raise a WAW hazard when issue_wr and the destination counter > issue_lat.
REQ-024 SHALL drive stall_dp combinationally as the OR of the RAW, WAW and structural (REQ-026) hazards, and only while issue_valid.
REQ-025 SHALL treat issue_lat = 0 or issue_lat > MAX_LAT as latency 1.
REQ-026 SHALL keep writeback-slot vector wb[1..MAX_LAT]: bit k set means a writeback occurs k cycles from now; a structural hazard exists when issue_wr and wb[issue_lat].
REQ-027 SHALL update the slot vector each cycle as wb'[k] = wb[k+1] | (accept & issue_wr & issue_lat == k+1), with wb'[MAX_LAT] = 0.
REQ-028 SHALL assert idle when all counters are 0 and wb is all 0.
REQ-029 SHALL let flush override issue_valid: no state change from the offered instruction, and in-flight counters keep decrementing.

Reset
REQ-030 SHALL on rst clear all counters and wb in the same edge; rst overrides accept.
REQ-031 SHALL while rst is high output stall_dp = 0 and idle = 1, and on the first post-reset cycle every source is ready.

Configuration
REQ-032 SHALL with SB_WB_ARBITER_EN defined implement wb and the structural hazard (REQ-026, REQ-027).
REQ-033 SHALL without SB_WB_ARBITER_EN omit wb entirely: the structural hazard is 0 and idle depends on the counters only.

Structure
REQ-034 SHALL take MAX_LAT, LAT_W and a 6-bit register-id typedef {fpu, num} from the shared core package.
REQ-035 SHALL place the slot vector in one sub-module, sb_wb_slots, with inputs accept/lat and outputs conflict/busy.

Verification
REQ-036 SHALL cover RAW: issue f3, lat 4 -> next instruction reading f3 (fpu flag set) stalls for 3 cycles, then accepts.
REQ-037 SHALL cover file separation: int x3 reading while f3 is pending -> no stall; pending write to x0 followed by a read of x0 -> no stall.
REQ-038 SHALL cover WAW: f5 lat 6 then f5 lat 2 next cycle -> second instruction stalls until f5 counter <= 2.
REQ-039 SHALL cover the structural hazard (macro on): lat 3 then lat 2 next cycle -> second stalls 1 cycle; macro off -> no stall.
REQ-040 SHALL cover flush: flush while a dependent issue is offered -> no counter load and stall_dp follows RAW only; rst mid-flight -> idle = 1 the next cycle.
